// File: rtl/iir_pkg.sv
// Shared constants and helpers for the IIR filter chain: sample width, clog2 and a
// signed saturating clamp that also reports whether clamping happened.
package iir_pkg;

   localparam int unsigned IIR_DATA_W = 18;

   function automatic int unsigned clog2(input int unsigned value);
      int unsigned result;
      result = 0;
      for (int i = 0; i < 32; i++) begin
         if ((64'd1 << i) < 64'(value)) result = i + 1;
      end
      return result;
   endfunction

   // Clamp a sign-extended value into the signed range of out_w bits.
   function automatic logic signed [63:0] sat_signed(input logic signed [63:0] value,
                                                     input int unsigned out_w,
                                                     output logic sat);
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
      lo = -hi - 64'sd1;
      sat = 1'b0;
      if (value > hi) begin
         sat = 1'b1;
         return hi;
      end
      if (value < lo) begin
         sat = 1'b1;
         return lo;
      end
      return value;
   endfunction

endpackage

// File: rtl/iir_skid_fifo.sv
// Two-entry valid/ready FIFO. The head register keeps the last popped value when empty,
// and a simultaneous push and pop is always accepted, even when full.
module iir_skid_fifo #(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic [W-1:0] push_data,
   output logic         full,
   input  logic         pop,
   output logic [W-1:0] pop_data,
   output logic         valid
);

   logic [W-1:0] head_q;
   logic [W-1:0] tail_q;
   logic [1:0]   count_q;
   logic         do_pop;
   logic         do_push;

   always_comb begin
      do_pop  = pop && (count_q != 2'd0);
      do_push = push && ((count_q != 2'd2) || do_pop);
      full     = (count_q == 2'd2);
      valid    = (count_q != 2'd0);
      pop_data = head_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= 2'd0;
      end else begin
         if (do_pop && (count_q == 2'd2)) begin
            head_q <= tail_q;
            if (do_push) tail_q <= push_data;
         end else if (do_pop) begin
            if (do_push) head_q <= push_data;
         end else if (do_push) begin
            if (count_q == 2'd0) head_q <= push_data;
            else                 tail_q <= push_data;
         end
         count_q <= count_q + {1'b0, do_push} - {1'b0, do_pop};
      end
   end

endmodule

// File: rtl/iir_decim.sv
// Accumulate-and-dump decimator with shift scaling, saturation and a 2-entry output buffer.
// Define DECIM_ROUND_EN to round half toward +inf before saturation instead of truncating.
module iir_decim
   import iir_pkg::*;
#(
   parameter int unsigned IN_W  = IIR_DATA_W,
   parameter int unsigned OUT_W = 8,
   parameter int unsigned DECIM = 4,
   parameter int unsigned SHIFT = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic signed [IN_W-1:0]  data_in,
   input  logic                    in_valid,
   output logic signed [OUT_W-1:0] out_data,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic                    sat_flag,
   output logic                    overrun
);

   localparam int unsigned CNT_W = clog2(DECIM);
   localparam int unsigned ACC_W = IN_W + CNT_W;

   logic signed [ACC_W-1:0] acc_q;
   logic [CNT_W-1:0]        cnt_q;
   logic signed [ACC_W:0]   sum_ext;
   logic signed [ACC_W:0]   biased;
   logic signed [ACC_W:0]   shifted;
   logic signed [63:0]      wide;
   logic signed [63:0]      clamped;
   logic                    clamp_hit;
   logic                    block_end;
   logic                    pop;
   logic                    full;
   logic [OUT_W-1:0]        q;
   logic [OUT_W-1:0]        head;

`ifdef DECIM_ROUND_EN
   localparam logic [ACC_W:0] RND = (SHIFT > 0) ? ((ACC_W + 1)'(1) << (SHIFT - 1)) : '0;
`endif

   always_comb begin
      sum_ext = {acc_q[ACC_W-1], acc_q} + {{(ACC_W + 1 - IN_W){data_in[IN_W-1]}}, data_in};
`ifdef DECIM_ROUND_EN
      biased = sum_ext + RND;
`else
      biased = sum_ext;
`endif
      shifted   = biased >>> SHIFT;
      wide      = {{(63 - ACC_W){shifted[ACC_W]}}, shifted};
      clamp_hit = 1'b0;
      clamped   = sat_signed(wide, OUT_W, clamp_hit);
      q         = clamped[OUT_W-1:0];
      block_end = in_valid && (cnt_q == CNT_W'(DECIM - 1));
      pop       = out_valid && out_ready;
      out_data  = head;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q    <= '0;
         cnt_q    <= '0;
         sat_flag <= 1'b0;
         overrun  <= 1'b0;
      end else begin
         if (block_end) begin
            acc_q <= '0;
            cnt_q <= '0;
            if (clamp_hit) sat_flag <= 1'b1;
            // Buffer full and nothing leaving this edge: the new result is lost.
            if (full && !pop) overrun <= 1'b1;
         end else if (in_valid) begin
            acc_q <= sum_ext[ACC_W-1:0];
            cnt_q <= cnt_q + 1'b1;
         end
      end
   end

   iir_skid_fifo #(
      .W(OUT_W)
   ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (block_end),
      .push_data(q),
      .full     (full),
      .pop      (pop),
      .pop_data (head),
      .valid    (out_valid)
   );

endmodule

// File: tb/tb_iir_decim.sv
// Directed and randomized bench for iir_decim against a queue-based arithmetic model.
module tb_iir_decim;

   localparam int DECIM = 4;
   localparam int SHIFT = 2;
   localparam int OUT_W = 8;
   localparam int IN_W  = 18;

   logic                    clk = 1'b0;
   logic                    rst = 1'b0;
   logic signed [IN_W-1:0]  data_in = '0;
   logic                    in_valid = 1'b0;
   logic signed [OUT_W-1:0] out_data;
   logic                    out_valid;
   logic                    out_ready = 1'b0;
   logic                    sat_flag;
   logic                    overrun;

   int total  = 0;
   int passed = 0;
   int failed = 0;

   int exp_q[$];
   int last_out = 0;
   int blk_sum  = 0;
   int blk_n    = 0;
   bit sat_m    = 1'b0;
   bit ovr_m    = 1'b0;

   always #5 clk = ~clk;

   iir_decim #(
      .IN_W (IN_W),
      .OUT_W(OUT_W),
      .DECIM(DECIM),
      .SHIFT(SHIFT)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .data_in  (data_in),
      .in_valid (in_valid),
      .out_data (out_data),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .sat_flag (sat_flag),
      .overrun  (overrun)
   );

   function automatic int block_result(input int sum, output bit sat);
      int s;
      int lim_hi;
      int lim_lo;
      s = sum;
`ifdef DECIM_ROUND_EN
      if (SHIFT > 0) s = s + (1 << (SHIFT - 1));
`endif
      s      = s >>> SHIFT;
      lim_hi = (1 << (OUT_W - 1)) - 1;
      lim_lo = -(1 << (OUT_W - 1));
      sat    = 1'b0;
      if (s > lim_hi) begin
         sat = 1'b1;
         s   = lim_hi;
      end else if (s < lim_lo) begin
         sat = 1'b1;
         s   = lim_lo;
      end
      return s;
   endfunction

   task automatic chk(input string tag, input int obs, input int exp);
      total++;
      assert (obs === exp) begin
         passed++;
      end else begin
         failed++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_edge(input bit r, input bit v, input int din, input bit rdy);
      bit have_res;
      bit s;
      int res;
      have_res = 1'b0;
      res      = 0;
      if (r) begin
         exp_q.delete();
         last_out = 0;
         blk_sum  = 0;
         blk_n    = 0;
         sat_m    = 1'b0;
         ovr_m    = 1'b0;
      end else begin
         if (v) begin
            blk_sum += din;
            blk_n++;
            if (blk_n == DECIM) begin
               res = block_result(blk_sum, s);
               if (s) sat_m = 1'b1;
               have_res = 1'b1;
               blk_sum  = 0;
               blk_n    = 0;
            end
         end
         if (rdy && exp_q.size() > 0) last_out = exp_q.pop_front();
         if (have_res) begin
            if (exp_q.size() < 2) exp_q.push_back(res);
            else ovr_m = 1'b1;
         end
      end
   endtask

   task automatic check_outputs(input string tag);
      int exp_data;
      exp_data = (exp_q.size() > 0) ? exp_q[0] : last_out;
      chk({tag, "_valid"}, int'(out_valid), int'(exp_q.size() > 0));
      chk({tag, "_data"}, int'(out_data), exp_data);
      chk({tag, "_sat"}, int'(sat_flag), int'(sat_m));
      chk({tag, "_ovr"}, int'(overrun), int'(ovr_m));
   endtask

   task automatic cycle(input string tag, input bit r, input bit v, input int din,
                        input bit rdy);
      rst       = r;
      in_valid  = v;
      data_in   = IN_W'(din);
      out_ready = rdy;
      @(posedge clk);
      model_edge(r, v, din, rdy);
      #1;
      check_outputs(tag);
   endtask

   initial begin
      int din;
      bit v;
      bit rdy;
      bit r;

      cycle("rst0", 1'b1, 1'b0, 0, 1'b0);
      cycle("rst1", 1'b1, 1'b1, 77, 1'b1);
      chk("reset_valid", int'(out_valid), 0);
      chk("reset_data", int'(out_data), 0);

      // Basic block of 5s
      for (int i = 0; i < 4; i++) cycle("t1", 1'b0, 1'b1, 5, 1'b1);
      chk("t1_const_valid", int'(out_valid), 1);
      chk("t1_const_data", int'(out_data), 5);
      cycle("t1_pop", 1'b0, 1'b0, 0, 1'b1);
      chk("t1_after_valid", int'(out_valid), 0);

      // Negative block, floor vs round
      for (int i = 0; i < 4; i++) cycle("t2", 1'b0, 1'b1, -7 + i, 1'b1);
`ifdef DECIM_ROUND_EN
      chk("t2_const_data", int'(out_data), -5);
`else
      chk("t2_const_data", int'(out_data), -6);
`endif

      // Saturation both directions
      for (int i = 0; i < 4; i++) cycle("t3p", 1'b0, 1'b1, 1000, 1'b1);
      chk("t3_const_hi", int'(out_data), 127);
      chk("t3_const_sat", int'(sat_flag), 1);
      for (int i = 0; i < 4; i++) cycle("t3n", 1'b0, 1'b1, -1000, 1'b1);
      chk("t3_const_lo", int'(out_data), -128);

      // Backpressure and overrun
      cycle("t4_pre", 1'b0, 1'b0, 0, 1'b1);
      for (int b = 1; b <= 3; b++)
         for (int i = 0; i < 4; i++) cycle("t4", 1'b0, 1'b1, b, 1'b0);
      chk("t4_const_head", int'(out_data), 1);
      chk("t4_const_ovr", int'(overrun), 1);
      cycle("t4_pop1", 1'b0, 1'b0, 0, 1'b1);
      chk("t4_const_second", int'(out_data), 2);
      cycle("t4_pop2", 1'b0, 1'b0, 0, 1'b1);
      chk("t4_const_empty", int'(out_valid), 0);

      // Gapped input
      cycle("t5_rst", 1'b1, 1'b0, 0, 1'b1);
      for (int i = 0; i < 4; i++) begin
         cycle("t5", 1'b0, 1'b1, 5, 1'b1);
         if (i < 3) cycle("t5_gap", 1'b0, 1'b0, 99, 1'b1);
      end
      chk("t5_const_data", int'(out_data), 5);

      // Reset aborts a partial block
      cycle("t6", 1'b0, 1'b1, 100, 1'b1);
      cycle("t6", 1'b0, 1'b1, 100, 1'b1);
      cycle("t6_rst", 1'b1, 1'b0, 0, 1'b1);
      for (int i = 0; i < 4; i++) cycle("t6", 1'b0, 1'b1, 8, 1'b1);
      chk("t6_const_data", int'(out_data), 8);
      chk("t6_const_flags", int'({sat_flag, overrun}), 0);

      // Randomized traffic
      for (int n = 0; n < 600; n++) begin
         v   = ($urandom_range(0, 3) != 0);
         rdy = ($urandom_range(0, 2) != 0);
         r   = ($urandom_range(0, 150) == 0);
         if ($urandom_range(0, 4) == 0) begin
            din = int'($urandom_range(0, 32'h3FFFF));
            if (din >= 32'h20000) din = din - 32'h40000;
         end else begin
            din = int'($urandom_range(0, 1200)) - 600;
         end
         cycle("rand", r, v, din, rdy);
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
